// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset PC, NOP
// encoding, FSM states and the {pc, instr} payload carried toward IF/ID.
package if_fetch_stage_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 2;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/if_fetch_stage_fetch_queue.sv
// Two-entry synchronous FIFO with flush; head entry is always at slot 0 so the
// output is taken straight from a register.
module fetch_queue
   import if_fetch_stage_pkg::*;
#(
   parameter int unsigned       DATA_W    = 32,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] head_o,
   output logic [CNT_W-1:0]  count_o
);

   logic [DATA_W-1:0] ent0_q, ent0_d;
   logic [DATA_W-1:0] ent1_q, ent1_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  slot;
   logic              do_push;
   logic              do_pop;

   always_comb begin
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      count_d = count_q;
      do_pop  = pop_i && (count_q != CNT_W'(0));
      do_push = push_i && ((count_q != CNT_W'(2)) || do_pop);
      slot    = count_q - CNT_W'(do_pop);
      if (flush_i) begin
         count_d = CNT_W'(0);
      end else begin
         if (do_pop) begin
            ent0_d = ent1_q;
         end
         // Write lands in the first free slot after any shift caused by the pop.
         if (do_push) begin
            if (slot == CNT_W'(0)) begin
               ent0_d = data_i;
            end else begin
               ent1_d = data_i;
            end
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ent0_q  <= RESET_VAL;
         ent1_q  <= RESET_VAL;
         count_q <= CNT_W'(0);
      end else begin
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
         count_q <= count_d;
      end
   end

   assign head_o  = ent0_q;
   assign count_o = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, issues credit-limited word fetches,
// buffers responses in order, and discards stale fetches after a redirect.
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid_o,
   input  logic            imem_req_ready_i,
   output logic [XLEN-1:0] imem_req_addr_o,
   input  logic            imem_rsp_valid_i,
   input  logic [XLEN-1:0] imem_rsp_data_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic            stall_i,
   output logic            if_valid_o,
   output logic [XLEN-1:0] if_pc_o,
   output logic [XLEN-1:0] if_pc_plus4_o,
   output logic [XLEN-1:0] if_instr_o
);

   localparam int unsigned OCC_W = CNT_W + 1;

   fetch_state_e     state_q, state_d;
   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   logic             q_flush;
   logic             pend_push;
   logic             out_push;
   logic             out_pop;
   logic [XLEN-1:0]  pend_head;
   logic [CNT_W-1:0] pend_count;
   fetch_entry_t     out_head;
   fetch_entry_t     out_new;
   logic [CNT_W-1:0] out_count;

   logic             consume;
   logic [OCC_W-1:0] occupancy;
   logic             req_fire;
   logic             rsp_ok;

   // An entry leaving IF/ID this cycle frees its slot immediately, which is what
   // lets a single-cycle memory sustain one fetch per cycle.
   always_comb begin
      consume   = if_valid_o && !stall_i;
      occupancy = OCC_W'(outstanding_q) + OCC_W'(out_count) - OCC_W'(consume);
      imem_req_valid_o = !rst && (state_q == ST_RUN) && !redirect_valid_i
                         && (occupancy < OCC_W'(2));
      req_fire  = imem_req_valid_o && imem_req_ready_i;
      rsp_ok    = imem_rsp_valid_i &&
                  ((state_q == ST_DRAIN) ? (drop_cnt_q != CNT_W'(0))
                                         : (pend_count != CNT_W'(0)));
   end

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      q_flush       = 1'b0;
      pend_push     = 1'b0;
      out_push      = 1'b0;
      out_pop       = 1'b0;
      if (redirect_valid_i) begin
         fetch_pc_d    = {redirect_pc_i[XLEN-1:2], 2'b00};
         q_flush       = 1'b1;
         drop_cnt_d    = outstanding_q - CNT_W'(rsp_ok);
         outstanding_d = drop_cnt_d;
         state_d       = (drop_cnt_d != CNT_W'(0)) ? ST_DRAIN : ST_RUN;
      end else if (state_q == ST_RUN) begin
         pend_push     = req_fire;
         out_push      = rsp_ok;
         out_pop       = consume;
         outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_ok);
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
         end
      end else begin
         // Stale responses are swallowed until every pre-redirect fetch has returned.
         if (rsp_ok) begin
            drop_cnt_d    = drop_cnt_q - CNT_W'(1);
            outstanding_d = outstanding_q - CNT_W'(1);
            if (drop_cnt_q == CNT_W'(1)) begin
               state_d = ST_RUN;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_RUN;
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= CNT_W'(0);
         drop_cnt_q    <= CNT_W'(0);
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   assign out_new = '{pc: pend_head, instr: imem_rsp_data_i};

   fetch_queue #(
      .DATA_W    (XLEN),
      .RESET_VAL (RESET_PC)
   ) u_pend_q (
      .clk     (clk),
      .rst     (rst),
      .flush_i (q_flush),
      .push_i  (pend_push),
      .data_i  (fetch_pc_q),
      .pop_i   (out_push),
      .head_o  (pend_head),
      .count_o (pend_count)
   );

   fetch_queue #(
      .DATA_W    (ENTRY_W),
      .RESET_VAL ({RESET_PC, NOP_INSTR})
   ) u_out_q (
      .clk     (clk),
      .rst     (rst),
      .flush_i (q_flush),
      .push_i  (out_push),
      .data_i  (out_new),
      .pop_i   (out_pop),
      .head_o  (out_head),
      .count_o (out_count)
   );

   assign imem_req_addr_o = fetch_pc_q;
   assign if_valid_o      = (out_count != CNT_W'(0));
   assign if_pc_o         = out_head.pc;
   assign if_pc_plus4_o   = out_head.pc + XLEN'(4);
   assign if_instr_o      = if_valid_o ? out_head.instr : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: behavioural memory plus a program-order stream model,
// a reset/streaming/stall vector table, directed redirect/reset cases, random run.
module tb_if_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, ready, rsp_valid, redir, stall;
   logic [31:0] rsp_data, redir_pc;
   logic        req_valid, if_valid;
   logic [31:0] req_addr, if_pc, if_pc4, if_instr;

   always #5 clk = ~clk;

   if_fetch_stage dut (
      .clk              (clk),
      .rst              (rst),
      .imem_req_valid_o (req_valid),
      .imem_req_ready_i (ready),
      .imem_req_addr_o  (req_addr),
      .imem_rsp_valid_i (rsp_valid),
      .imem_rsp_data_i  (rsp_data),
      .redirect_valid_i (redir),
      .redirect_pc_i    (redir_pc),
      .stall_i          (stall),
      .if_valid_o       (if_valid),
      .if_pc_o          (if_pc),
      .if_pc_plus4_o    (if_pc4),
      .if_instr_o       (if_instr)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // memory: in-order list of accepted addresses and the cycle each may answer
   logic [31:0] mq_addr[$];
   int          mq_rdy[$];
   int          lat_min = 1, lat_max = 1;
   bit          rsp_gate = 1'b0;
   logic [31:0] data_key = 32'h0;

   // program-order expectations
   logic [31:0] exp_fetch = RST_PC;
   logic [31:0] exp_pc    = RST_PC;

   bit          p_hold = 0, p_redir = 0, p_stallhold = 0, p_rst = 0;
   logic [31:0] p_addr = '0;

   logic        s_rv, s_iv;
   logic [31:0] s_ra, s_ipc, s_ip4, s_ins;
   int          consumed = 0;

   typedef struct {
      bit          rst;
      bit          stall;
      bit          rv;
      logic [31:0] ra;
      bit          iv;
      logic [31:0] ipc;
   } vec_t;
   vec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      rsp_valid = 1'b0;
      rsp_data  = '0;
      if (mq_addr.size() > 0 && mq_rdy[0] <= cyc && (!rsp_gate || $urandom_range(3) != 0)) begin
         rsp_valid = 1'b1;
         rsp_data  = mq_addr[0] ^ data_key;
      end
      #1;
      s_rv = req_valid; s_ra = req_addr; s_iv = if_valid;
      s_ipc = if_pc; s_ip4 = if_pc4; s_ins = if_instr;
      if (rst) begin
         if (p_rst) begin
            chk("rst_req_valid", 32'(s_rv), 32'd0);
            chk("rst_req_addr", s_ra, RST_PC);
            chk("rst_if_valid", 32'(s_iv), 32'd0);
            chk("rst_if_pc", s_ipc, RST_PC);
            chk("rst_if_pc_plus4", s_ip4, RST_PC + 32'd4);
            chk("rst_if_instr", s_ins, NOP);
         end
      end else begin
         if (redir) chk("req_valid_on_redirect", 32'(s_rv), 32'd0);
         else if (s_rv) chk("req_addr_order", s_ra, exp_fetch);
         if (p_hold && !redir) begin
            chk("req_hold_valid", 32'(s_rv), 32'd1);
            chk("req_hold_addr", s_ra, p_addr);
         end
         if (p_redir) chk("if_valid_after_redirect", 32'(s_iv), 32'd0);
         if (p_stallhold) chk("stall_hold_valid", 32'(s_iv), 32'd1);
         if (s_iv) begin
            chk("if_pc_stream", s_ipc, exp_pc);
            chk("if_instr_stream", s_ins, exp_pc ^ data_key);
            chk("if_pc_plus4", s_ip4, exp_pc + 32'd4);
         end else begin
            chk("if_instr_nop", s_ins, NOP);
         end
      end
      p_hold      = !rst && s_rv && !ready;
      p_addr      = s_ra;
      p_redir     = !rst && redir;
      p_stallhold = !rst && !redir && s_iv && stall;
      p_rst       = rst;
      @(posedge clk);
      if (rst) begin
         mq_addr.delete();
         mq_rdy.delete();
         exp_fetch = RST_PC;
         exp_pc    = RST_PC;
      end else begin
         if (rsp_valid) begin
            void'(mq_addr.pop_front());
            void'(mq_rdy.pop_front());
         end
         if (redir) begin
            exp_fetch = {redir_pc[31:2], 2'b00};
            exp_pc    = {redir_pc[31:2], 2'b00};
         end else begin
            if (s_rv && ready) begin
               mq_addr.push_back(s_ra);
               mq_rdy.push_back(cyc + $urandom_range(lat_max, lat_min));
               exp_fetch = exp_fetch + 32'd4;
            end
            if (s_iv && !stall) begin
               exp_pc = exp_pc + 32'd4;
               consumed++;
            end
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; redir = 1'b0; stall = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_iv(input string name, input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         step();
         if (s_iv) break;
      end
      chk(name, 32'(s_iv), 32'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h04};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h14, 1'b1, 32'h0C};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h14, 1'b1, 32'h0C};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h14, 1'b1, 32'h0C};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h14, 1'b1, 32'h0C};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h14, 1'b1, 32'h0C};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
      tbl[13] = '{1'b0, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h14};

      rst = 1'b1; ready = 1'b1; redir = 1'b0; redir_pc = '0; stall = 1'b0;
      rsp_valid = 1'b0; rsp_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      p_rst = 1'b1;

      // reset, 1-cycle memory, then a 5-cycle stall mid-stream
      for (int i = 0; i < 14; i++) begin
         rst = tbl[i].rst; stall = tbl[i].stall;
         step();
         chk($sformatf("tbl%0d_req_valid", i), 32'(s_rv), 32'(tbl[i].rv));
         chk($sformatf("tbl%0d_req_addr", i), s_ra, tbl[i].ra);
         chk($sformatf("tbl%0d_if_valid", i), 32'(s_iv), 32'(tbl[i].iv));
         if (tbl[i].iv) chk($sformatf("tbl%0d_if_pc", i), s_ipc, tbl[i].ipc);
      end
      stall = 1'b0;
      repeat (4) step();

      // redirect with two fetches outstanding, 3-cycle memory
      lat_min = 3; lat_max = 3;
      do_reset();
      step();
      step();
      redir = 1'b1; redir_pc = 32'h0000_0100;
      step();
      redir = 1'b0;
      step(); chk("drain1_no_req", 32'(s_rv), 32'd0);
      step(); chk("drain2_no_req", 32'(s_rv), 32'd0);
      step(); chk("drain_exit_req", 32'(s_rv), 32'd1);
      chk("drain_exit_addr", s_ra, 32'h0000_0100);
      wait_iv("wait_0x100", 20);
      chk("first_pc_0x100", s_ipc, 32'h0000_0100);
      chk("first_instr_0x100", s_ins, 32'h0000_0100);

      // redirect coinciding with a response, then re-redirect while draining
      lat_min = 2; lat_max = 2;
      do_reset();
      step();
      step();
      redir = 1'b1; redir_pc = 32'h0000_0180;
      step();
      redir_pc = 32'h0000_0200;
      step();
      redir = 1'b0;
      step(); chk("req_0x200_valid", 32'(s_rv), 32'd1);
      chk("req_0x200_addr", s_ra, 32'h0000_0200);
      wait_iv("wait_0x200", 20);
      chk("first_pc_0x200", s_ipc, 32'h0000_0200);
      repeat (6) step();

      // misaligned target and PC wrap
      lat_min = 1; lat_max = 1;
      redir = 1'b1; redir_pc = 32'h0000_0106;
      step();
      redir = 1'b0;
      wait_iv("wait_0x104", 20);
      chk("first_pc_0x104", s_ipc, 32'h0000_0104);
      repeat (3) step();
      redir = 1'b1; redir_pc = 32'hFFFF_FFFC;
      step();
      redir = 1'b0;
      wait_iv("wait_wrap", 20);
      chk("wrap_pc", s_ipc, 32'hFFFF_FFFC);
      chk("wrap_pc_plus4", s_ip4, 32'h0000_0000);
      wait_iv("wait_after_wrap", 20);
      chk("pc_after_wrap", s_ipc, 32'h0000_0000);

      // memory not ready for 4 cycles, then reset mid-stream
      do_reset();
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("notready%0d_valid", i), 32'(s_rv), 32'd1);
         chk($sformatf("notready%0d_addr", i), s_ra, RST_PC);
      end
      ready = 1'b1;
      repeat (6) step();
      do_reset();
      step();
      chk("restart_req_valid", 32'(s_rv), 32'd1);
      chk("restart_req_addr", s_ra, RST_PC);
      wait_iv("wait_restart", 20);
      chk("restart_pc", s_ipc, RST_PC);

      // randomized traffic against the stream model
      lat_min = 1; lat_max = 4; rsp_gate = 1'b1; data_key = 32'h5A5A_0000;
      do_reset();
      consumed = 0;
      for (int i = 0; i < 3000; i++) begin
         ready    = ($urandom_range(3) != 0);
         stall    = ($urandom_range(4) == 0);
         redir    = ($urandom_range(31) == 0);
         redir_pc = $urandom();
         rst      = ($urandom_range(255) == 0);
         step();
      end
      rst = 1'b0; redir = 1'b0; stall = 1'b0; ready = 1'b1;
      repeat (10) step();
      chk("random_progress", 32'(consumed > 300), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
